// File: rtl/proc_pkg.sv
// Shared fetch front-end types: the queued (PC, IR) entry, the NOP filler
// and the prefetch FSM states.
package proc_pkg;

  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  typedef enum logic {PF_FETCH, PF_DRAIN} pf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; DEPTH must
// be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue between instruction memory and the IF stage.
// Optional `IF_PREFETCH_PERF_EN adds flush and starvation counters.
module if_prefetch_buffer
  import proc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_npc,
  output logic [31:0] inst_ir
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_empty_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t    state, state_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic [CW-1:0] outstanding, outstanding_next;
  logic [CW-1:0] drop_cnt, drop_cnt_next;
  logic [CW-1:0] pending;
  logic [CW-1:0] entry_count, pc_count;
  logic         entry_full, entry_empty, pc_full, pc_empty;
  logic [31:0]  rsp_pc;
  fetch_entry_t head, tail;
  logic         fire, rsp_keep, pop_head;

  assign tail = '{pc: rsp_pc, ir: imem_rsp_data};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(rsp_keep), .wdata(tail), .pop(pop_head), .rdata(head),
    .full(entry_full), .empty(entry_empty), .count(entry_count)
  );

  // Addresses of requests still owed a response, in issue order.
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(fire), .wdata(fetch_pc), .pop(rsp_keep), .rdata(rsp_pc),
    .full(pc_full), .empty(pc_empty), .count(pc_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= PF_FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

  // Redirect overrides issue, response capture and pop in the same cycle.
  always_comb begin
    imem_req_valid   = rst && (state == PF_FETCH) && !redirect_valid
                       && (({1'b0, entry_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH))
                       && (outstanding < CW'(MAX_OUTST));
    imem_req_addr    = fetch_pc;
    fire             = imem_req_valid && imem_req_ready;
    rsp_keep         = imem_rsp_valid && !redirect_valid && (drop_cnt == '0)
                       && (outstanding != '0);
    inst_valid       = !entry_empty && !redirect_valid;
    pop_head         = inst_valid && inst_ready;
    inst_pc          = inst_valid ? head.pc : 32'h0;
    inst_npc         = inst_pc + 32'd4;
    inst_ir          = inst_valid ? head.ir : NOOP_INST;
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    outstanding_next = outstanding;
    drop_cnt_next    = drop_cnt;
    pending          = drop_cnt + outstanding;

    if (redirect_valid) begin
      if (imem_rsp_valid && pending != '0) pending = pending - 1'b1;
      fetch_pc_next    = redirect_pc;
      outstanding_next = '0;
      drop_cnt_next    = pending;
      state_next       = (pending != '0) ? PF_DRAIN : PF_FETCH;
    end else begin
      if (fire) fetch_pc_next = fetch_pc + 32'd4;
      outstanding_next = outstanding + CW'(fire) - CW'(rsp_keep);
      if (imem_rsp_valid && drop_cnt != '0) drop_cnt_next = drop_cnt - 1'b1;
      if (state == PF_DRAIN && drop_cnt_next == '0) state_next = PF_FETCH;
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_flush_cnt <= '0;
      perf_empty_cnt <= '0;
    end else begin
      if (redirect_valid && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (inst_ready && !inst_valid && !redirect_valid && perf_empty_cnt != '1)
        perf_empty_cnt <= perf_empty_cnt + 1'b1;
    end
  end
`else
  // Default build carries no performance counters.
`endif

  // Stray responses and internal bookkeeping drift are flagged in simulation.
  assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && outstanding == '0 && drop_cnt == '0));
  assert property (@(posedge clk) disable iff (!rst) pc_count == outstanding);
  assert property (@(posedge clk) disable iff (!rst) !(fire && pc_full));
  assert property (@(posedge clk) disable iff (!rst) !(rsp_keep && pc_empty));
  assert property (@(posedge clk) disable iff (!rst) !(rsp_keep && entry_full && !pop_head));

endmodule
